seg_display_scanner: RTL

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. It takes the stopwatch's BCD digit word plus per-digit blank/blink/decimal-point masks and scans one digit per slot. Inputs are snapshotted once per frame so a count update never tears mid-frame. It is the output-side counterpart to the button front end and sits between the stopwatch counter and the FPGA pins.

---
 rtl/seg_pkg.sv | 39 +++
 rtl/seg7_decode.sv | 14 +
 rtl/seg_display_scanner.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment constants and digit table
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    // Bit positions inside a {g,f,e,d,c,b,a} segment word
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-low segment patterns: a 0 bit lights the segment
    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    // Nibble to segment table; non-BCD codes show a centre dash
    localparam logic [6:0] SEG_TABLE [0:15] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        SEG_DASH,    // A
        SEG_DASH,    // B
        SEG_DASH,    // C
        SEG_DASH,    // D
        SEG_DASH,    // E
        SEG_DASH     // F
    };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational nibble to active-low segment lookup
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Table lookup; invalid BCD codes are already mapped to a dash in the table
    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/seg_display_scanner.sv
// rtl/seg_display_scanner.sv - 4-digit multiplexed seven-segment scanner with frame snapshot
module seg_display_scanner
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int GUARD     = 16,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   digits_i,
    input  logic [NUM_DIGITS-1:0]     blank_i,
    input  logic [NUM_DIGITS-1:0]     blink_i,
    input  logic [NUM_DIGITS-1:0]     dp_i,
    output logic [NUM_DIGITS-1:0]     an_o,
    output logic [6:0]                seg_o,
    output logic                      dp_o,
    output logic                      frame_o
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam int BLK_W = $clog2(BLINK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0]            cnt;
    logic [1:0]                  idx;
    logic                        slot_end;
    logic                        frame_end;

    logic [BLK_W-1:0]            blink_cnt;
    logic                        phase;

    logic [4*NUM_DIGITS-1:0]     sh_digits;
    logic [NUM_DIGITS-1:0]       sh_blank;
    logic [NUM_DIGITS-1:0]       sh_blink;
    logic [NUM_DIGITS-1:0]       sh_dp;

    logic [3:0]                  cur_nibble;
    logic [6:0]                  cur_seg;
    logic                        visible;
    logic [NUM_DIGITS-1:0]       an_next;
    logic [6:0]                  seg_next;
    logic                        dp_next;

    assign slot_end  = (cnt == CNT_LAST);
    assign frame_end = slot_end && (idx == 2'd3);

    // Slot counter and digit index; idx advances on each slot wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Free-running blink divider, independent of the scan position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Snapshot inputs at the frame boundary so a frame never mixes two counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits <= '0;
            sh_blank  <= '1;
            sh_blink  <= '0;
            sh_dp     <= '0;
        end else if (frame_end) begin
            sh_digits <= digits_i;
            sh_blank  <= blank_i;
            sh_blink  <= blink_i;
            sh_dp     <= dp_i;
        end
    end

    assign cur_nibble = sh_digits[{idx, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // Visibility: past the guard, not blanked, not in the dark blink phase
    always_comb begin
        visible  = 1'b0;
        an_next  = '1;
        seg_next = SEG_OFF;
        dp_next  = 1'b1;
        if ((cnt >= CNT_GUARD) && !sh_blank[idx] && !(sh_blink[idx] && phase)) begin
            visible = 1'b1;
        end
        if (visible) begin
            an_next  = ~(NUM_DIGITS'(1) << idx);
            seg_next = cur_seg;
            dp_next  = ~sh_dp[idx];
        end
    end

    // Registered pins; frame_o marks the first cycle after the snapshot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_o    <= '1;
            seg_o   <= SEG_OFF;
            dp_o    <= 1'b1;
            frame_o <= 1'b0;
        end else begin
            an_o    <= an_next;
            seg_o   <= seg_next;
            dp_o    <= dp_next;
            frame_o <= frame_end;
        end
    end

endmodule
